// File: rtl/char_fetch_sequencer.sv
// Text-mode fetch sequencer: reads one character code per 8-pixel cell from the
// text buffer and shares that single buffer port with host writes.
module char_fetch_sequencer #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int CHAR_H   = 16,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int LEAD_X   = 792,
    parameter int DATA_W   = 8
) (
    input  logic              Pixelclock,
    input  logic              Reset,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              active,
    input  logic              host_req,
    input  logic [11:0]       host_addr,
    input  logic [DATA_W-1:0] host_char,
    output logic              host_ready,
    output logic [11:0]       tb_addr,
    output logic              tb_we,
    output logic [DATA_W-1:0] tb_wdata,
    input  logic [DATA_W-1:0] tb_rdata,
    output logic [DATA_W-1:0] character,
    output logic [3:0]        glyph_row,
    output logic [2:0]        glyph_col,
    output logic              char_valid
);

    localparam int                ROW_SH = $clog2(CHAR_H);
    localparam logic [11:0]       CELLS  = 12'(COLS * ROWS);
    localparam logic [DATA_W-1:0] SPACE  = DATA_W'(32'h20);

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_LEAD   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [9:0]        y_next;
    logic [6:0]        cell_col;
    logic              lead_fetch;
    logic              cell_fetch;
    logic              fetch_slot;
    logic [11:0]       fetch_addr;
    logic              host_in_range;
    logic [11:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cell_fetch_p1;
    logic              primed;
    logic              lead_capture;
    logic              capture;
    logic [DATA_W-1:0] next_char;

    function automatic logic [11:0] row_base(input logic [9:0] y);
        logic [9:0] row;
        row = y >> ROW_SH;
        return 12'(row) * 12'(COLS);
    endfunction

    // Fetch slot decode: lead fetch in h-blank, then one read per cell ahead of display
    always_comb begin
        y_next        = (pix_y == 10'(V_TOTAL - 1)) ? 10'd0 : pix_y + 10'd1;
        cell_col      = pix_x[9:3];
        lead_fetch    = (pix_x == 10'(LEAD_X)) && (y_next < 10'(V_ACTIVE));
        cell_fetch    = active && (pix_x < 10'(H_ACTIVE)) && (pix_x[2:0] == 3'd0)
                        && (({1'b0, cell_col} + 8'd1) < 8'(COLS));
        fetch_slot    = lead_fetch | cell_fetch;
        fetch_addr    = lead_fetch ? row_base(y_next)
                                   : row_base(pix_y) + 12'(cell_col) + 12'd1;
        host_in_range = host_addr < CELLS;
    end

    // Buffer port arbitration: display fetch has fixed priority over the host
    always_comb begin
        host_ready = 1'b0;
        tb_we      = 1'b0;
        tb_addr    = addr_q;
        tb_wdata   = wdata_q;
        if (Reset) begin
            tb_addr  = '0;
            tb_wdata = '0;
        end else if (fetch_slot) begin
            tb_addr = fetch_addr;
        end else if (host_req) begin
            host_ready = 1'b1;
            tb_addr    = host_addr;
            tb_wdata   = host_char;
            tb_we      = host_in_range;
        end
    end

    always_ff @(posedge Pixelclock) begin
        if (Reset) state <= S_BLANK;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BLANK:  if (lead_fetch) state_nxt = S_LEAD;
                      else if (active) state_nxt = S_ACTIVE;
            S_LEAD:   state_nxt = active ? S_ACTIVE : S_BLANK;
            S_ACTIVE: if (!active) state_nxt = S_BLANK;
            default:  state_nxt = S_BLANK;
        endcase
    end

    // Cell reads are only trusted once a lead fetch has re-synchronised the line
    always_comb begin
        lead_capture = (state == S_LEAD);
        capture      = lead_capture | ((state == S_ACTIVE) & cell_fetch_p1 & primed);
    end

    // Stage p1: read data capture and registered display outputs
    always_ff @(posedge Pixelclock) begin
        if (Reset) begin
            cell_fetch_p1 <= 1'b0;
            primed        <= 1'b0;
            next_char     <= SPACE;
            addr_q        <= '0;
            wdata_q       <= '0;
            character     <= '0;
            glyph_row     <= '0;
            glyph_col     <= '0;
            char_valid    <= 1'b0;
        end else begin
            cell_fetch_p1 <= cell_fetch;
            addr_q        <= tb_addr;
            wdata_q       <= tb_wdata;
            if (lead_capture) primed <= 1'b1;
            if (capture) next_char <= tb_rdata;
            glyph_col  <= pix_x[2:0];
            glyph_row  <= pix_y[3:0] & 4'(CHAR_H - 1);
            char_valid <= active;
            if (active && (pix_x[2:0] == 3'd0)) character <= next_char;
        end
    end

endmodule

// File: tb/tb_char_fetch_sequencer.sv
// Directed bench for char_fetch_sequencer: synchronous-read text buffer model
// plus a queue of expected character codes checked one cycle after each cell.
module tb_char_fetch_sequencer;

    logic        Pixelclock = 1'b0;
    logic        Reset;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        active;
    logic        host_req;
    logic [11:0] host_addr;
    logic [7:0]  host_char;
    logic        host_ready;
    logic [11:0] tb_addr;
    logic        tb_we;
    logic [7:0]  tb_wdata;
    logic [7:0]  tb_rdata;
    logic [7:0]  character;
    logic [3:0]  glyph_row;
    logic [2:0]  glyph_col;
    logic        char_valid;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] ram    [0:4095];
    logic [7:0] shadow [0:4095];
    logic ld = 1'b0;
    bit   exp_blank = 1'b1;
    bit   chk_en = 1'b0;

    typedef struct {
        logic [7:0] code;
        int         x;
        int         y;
    } exp_t;
    exp_t sb[$];

    char_fetch_sequencer dut (
        .Pixelclock (Pixelclock),
        .Reset      (Reset),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .active     (active),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_char  (host_char),
        .host_ready (host_ready),
        .tb_addr    (tb_addr),
        .tb_we      (tb_we),
        .tb_wdata   (tb_wdata),
        .tb_rdata   (tb_rdata),
        .character  (character),
        .glyph_row  (glyph_row),
        .glyph_col  (glyph_col),
        .char_valid (char_valid)
    );

    always #5 Pixelclock = ~Pixelclock;

    function automatic logic [7:0] pat(input int i);
        return 8'(32'h41 + (i % 80) + (i / 80));
    endfunction

    always @(posedge Pixelclock) begin
        if (ld) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
        end else if (tb_we) begin
            ram[tb_addr] <= tb_wdata;
        end
        tb_rdata <= ram[tb_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int x, input int y);
        exp_t e;
        int   ynx;
        pix_x  = 10'(x);
        pix_y  = 10'(y);
        active = (x < 640) && (y < 480);
        #1;
        if (chk_en && active && (x % 8 == 0)) begin
            e.code = exp_blank ? 8'h20 : shadow[(y / 16) * 80 + x / 8];
            e.x    = x;
            e.y    = y;
            sb.push_back(e);
        end
        ynx = (y == 524) ? 0 : y + 1;
        if (x == 792 && ynx < 480) exp_blank = 1'b0;
    endtask

    task automatic edge_chk();
        exp_t e;
        logic act_prev;
        act_prev = active;
        @(posedge Pixelclock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("char_y%0d_x%0d", e.y, e.x), character, e.code);
        end
        if (chk_en) check("char_valid", char_valid, act_prev);
    endtask

    task automatic run(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            set_pix(x, y);
            edge_chk();
        end
    endtask

    initial begin
        int k;
        int done_at;
        Reset     = 1'b1;
        host_req  = 1'b0;
        host_addr = '0;
        host_char = '0;
        pix_x     = '0;
        pix_y     = '0;
        active    = 1'b0;
        for (int i = 0; i < 4096; i++) shadow[i] = pat(i);
        ld = 1'b1;
        @(posedge Pixelclock);
        #1;
        ld = 1'b0;

        // Power-on reset with a pending host request that must not be granted
        host_req  = 1'b1;
        host_addr = 12'd7;
        host_char = 8'h11;
        for (int x = 780; x < 783; x++) begin
            set_pix(x, 524);
            check("rst_host_ready", host_ready, 0);
            check("rst_tb_we", tb_we, 0);
            check("rst_tb_addr", tb_addr, 0);
            check("rst_tb_wdata", tb_wdata, 0);
            edge_chk();
            check("rst_character", character, 0);
            check("rst_glyph_row", glyph_row, 0);
            check("rst_glyph_col", glyph_col, 0);
            check("rst_char_valid", char_valid, 0);
        end
        Reset    = 1'b0;
        host_req = 1'b0;
        chk_en   = 1'b1;

        // Lead fetch on the last line, then render line 0
        for (int x = 783; x < 800; x++) begin
            set_pix(x, 524);
            if (x == 792) begin
                check("lead_addr_line0", tb_addr, 0);
                check("lead_we", tb_we, 0);
            end
            edge_chk();
        end
        run(0, 0, 799);

        // Line 37: fetch addresses, glyph outputs, host collision and last-column slot
        run(36, 780, 799);
        for (int x = 0; x < 800; x++) begin
            set_pix(x, 37);
            if (x % 8 == 0 && x < 632) check($sformatf("cell_addr_x%0d", x), tb_addr, 161 + x / 8);
            if (x == 8) begin
                host_req = 1'b1; host_addr = 12'd5; host_char = 8'h7E;
                #1;
                check("collide_ready_fetch", host_ready, 0);
                check("collide_we_fetch", tb_we, 0);
            end
            if (x == 9) begin
                check("collide_ready_next", host_ready, 1);
                check("collide_we", tb_we, 1);
                check("collide_addr", tb_addr, 5);
                check("collide_wdata", tb_wdata, 8'h7E);
                shadow[5] = 8'h7E;
            end
            if (x == 632) begin
                host_req = 1'b1; host_addr = 12'd1500; host_char = 8'h33;
                #1;
                check("lastcol_ready", host_ready, 1);
                check("lastcol_we", tb_we, 1);
                check("lastcol_addr", tb_addr, 1500);
                shadow[1500] = 8'h33;
            end
            if (x == 700) begin
                host_req = 1'b1; host_addr = 12'd2400; host_char = 8'h55;
                #1;
                check("oob_ready", host_ready, 1);
                check("oob_we", tb_we, 0);
            end
            if (x == 701) begin
                host_req = 1'b1; host_addr = 12'd2399; host_char = 8'h5A;
                #1;
                check("blank_wr_ready", host_ready, 1);
                check("blank_wr_we", tb_we, 1);
                shadow[2399] = 8'h5A;
            end
            if (x == 792) begin
                check("lead_addr_line38", tb_addr, 160);
                check("lead_ready_blocked", host_ready, 0);
            end
            edge_chk();
            if (x == 9 || x == 632 || x == 700 || x == 701) host_req = 1'b0;
            check("glyph_col", glyph_col, x % 8);
            check("glyph_row", glyph_row, 5);
        end

        // Mid-frame reset on line 100
        chk_en = 1'b0;
        run(100, 296, 299);
        Reset     = 1'b1;
        host_req  = 1'b1;
        host_addr = 12'd9;
        host_char = 8'h66;
        for (int x = 300; x < 303; x++) begin
            set_pix(x, 100);
            check("mid_rst_host_ready", host_ready, 0);
            check("mid_rst_tb_we", tb_we, 0);
            check("mid_rst_tb_addr", tb_addr, 0);
            check("mid_rst_tb_wdata", tb_wdata, 0);
            edge_chk();
            check("mid_rst_character", character, 0);
            check("mid_rst_glyph_row", glyph_row, 0);
            check("mid_rst_glyph_col", glyph_col, 0);
            check("mid_rst_char_valid", char_valid, 0);
        end
        Reset     = 1'b0;
        host_req  = 1'b0;
        exp_blank = 1'b1;
        chk_en    = 1'b1;
        run(100, 303, 799);

        // Line 101 renders correctly; a write one cycle before a fetch is seen by it
        for (int x = 0; x < 800; x++) begin
            set_pix(x, 101);
            if (x == 7) begin
                host_req = 1'b1; host_addr = 12'd482; host_char = 8'h99;
                #1;
                check("pre_fetch_wr_ready", host_ready, 1);
                check("pre_fetch_wr_we", tb_we, 1);
                shadow[482] = 8'h99;
            end
            edge_chk();
            if (x == 7) host_req = 1'b0;
        end

        // Host burst of 64 writes during active line 0
        run(524, 780, 799);
        k       = 0;
        done_at = 0;
        for (int x = 0; x < 800; x++) begin
            set_pix(x, 0);
            if (k < 64) begin
                host_req  = 1'b1;
                host_addr = 12'(1000 + k);
                host_char = 8'(32'hC0 + k);
                #1;
                if (host_ready === 1'b1) begin
                    shadow[1000 + k] = host_char;
                    k++;
                    if (k == 64) done_at = x + 1;
                end
            end else begin
                host_req = 1'b0;
            end
            if (x % 8 == 0 && x < 632) begin
                check($sformatf("burst_fetch_addr_x%0d", x), tb_addr, 1 + x / 8);
                check($sformatf("burst_fetch_we_x%0d", x), tb_we, 0);
            end
            edge_chk();
        end
        host_req = 1'b0;
        check("burst_done_within_74", (done_at > 0) && (done_at <= 74), 1);

        // Final text-buffer contents
        check("ram_5", ram[5], 8'h7E);
        check("ram_9_untouched", ram[9], pat(9));
        check("ram_482", ram[482], 8'h99);
        check("ram_1500", ram[1500], 8'h33);
        check("ram_2399", ram[2399], 8'h5A);
        check("ram_2400_untouched", ram[2400], pat(2400));
        for (int i = 0; i < 64; i++) check($sformatf("ram_burst_%0d", i), ram[1000 + i], 8'(32'hC0 + i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
